adc_stream_sched: RTL

- Sequences and shares the single FT245R USB byte path between NCH CS5361 receiver channels.
- Owns ADC bring-up: holds the converters in reset, then waits a settle window.
- After that, captures each channel's 8-bit sample on its strobe and grants channels round-robin.
- Each granted sample is emitted as a tagged byte pair on a valid/ready byte stream that the USB FIFO writer consumes.

---
 rtl/adc_stream_sched_pkg.sv | 35 +++
 rtl/adc_stream_sched_if.sv | 15 +
 rtl/adc_stream_sched_rr_arbiter.sv | 31 +++
 rtl/adc_stream_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_stream_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_stream_pkg
// Brief   : Shared FSM states, tag layout and tag builder for adc_stream_sched.
// Revision: 1.0
// ============================================================================
package adc_stream_pkg;

  typedef enum logic [2:0] {
    ST_RST_ADC = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_IDLE    = 3'd2,
    ST_TAG     = 3'd3,
    ST_DATA    = 3'd4,
    ST_TS_HI   = 3'd5,
    ST_TS_LO   = 3'd6
  } state_e;

  localparam logic [1:0] TAG_PREFIX_PLAIN = 2'b10;
  localparam logic [1:0] TAG_PREFIX_TS    = 2'b11;
  localparam int         TAG_OVF_BIT      = 5;
  localparam int         TAG_CH_W         = 5;

  function automatic logic [7:0] make_tag(input logic [1:0] prefix, input logic ovf,
                                          input logic [TAG_CH_W-1:0] ch);
    logic [7:0] tag;
    tag                 = '0;
    tag[7:6]            = prefix;
    tag[TAG_OVF_BIT]    = ovf;
    tag[TAG_CH_W-1:0]   = ch;
    return tag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_stream_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : adc_stream_sched_if
// Brief   : Valid/ready byte stream towards the USB FIFO writer.
// Revision: 1.0
// ============================================================================
interface adc_stream_sched_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/adc_stream_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick, searching from last grant + 1.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  wire logic [NCH-1:0] req_i,
  input  wire logic [PW-1:0]  last_i,
  output logic      [PW-1:0]  grant_o,
  output logic                any_req_o
);

  logic [PW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest request wins.
  always_comb begin
    grant_o = last_i;
    idx     = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = PW'((int'(last_i) + k) % NCH);
      if (req_i[idx]) grant_o = idx;
    end
    any_req_o = |req_i;
  end

endmodule
`default_nettype wire

// File: rtl/adc_stream_sched.sv
`default_nettype none
// ============================================================================
// Module  : adc_stream_sched
// Brief   : CS5361 bring-up sequencer and round-robin tagged byte streamer.
//           Define ADC_STREAM_TIMESTAMP_EN to append a 16-bit timestamp.
// Revision: 1.0
// ============================================================================
module adc_stream_sched
  import adc_stream_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int RST_CYCLES    = 64,
  parameter int SETTLE_CYCLES = 256
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               enable,
  output logic                    adc_rst_,
  input  wire logic [NCH*8-1:0]   adcval,
  input  wire logic [NCH-1:0]     adcstrobe,
  adc_stream_sched_if.master      usb,
  output logic      [NCH-1:0]     lost,
  output logic                    running
);

  localparam int PW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef ADC_STREAM_TIMESTAMP_EN
  localparam logic [1:0] TAG_PREFIX = TAG_PREFIX_TS;
  localparam state_e     LAST_ST    = ST_TS_LO;
`else
  localparam logic [1:0] TAG_PREFIX = TAG_PREFIX_PLAIN;
  localparam state_e     LAST_ST    = ST_DATA;
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             adc_rst_q, running_q, abort_q;
  logic [PW-1:0]    ptr_q;
  logic [NCH-1:0]   pending_q, pending_d, ovf_q, ovf_d, lost_q, lost_d;
  logic [7:0]       hold_q [NCH];
  logic [7:0]       snap_q, out_data_q;
  logic             out_valid_q;
`ifdef ADC_STREAM_TIMESTAMP_EN
  logic [15:0]      ts_cnt_q, ts_snap_q;
  logic [15:0]      ts_hold_q [NCH];
`endif

  logic [PW-1:0] grant;
  logic          any_req, grant_fire, hs, end_xfer, flush, cap_en;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .req_i     (pending_q),
    .last_i    (ptr_q),
    .grant_o   (grant),
    .any_req_o (any_req)
  );

  always_comb begin
    hs         = out_valid_q && usb.out_ready;
    grant_fire = (state_q == ST_IDLE) && enable && any_req;
    end_xfer   = (state_q == LAST_ST) && hs;
    flush      = ((state_q == ST_IDLE) && !enable) || (end_xfer && (abort_q || !enable));
    cap_en     = enable && !abort_q &&
                 (state_q inside {ST_IDLE, ST_TAG, ST_DATA, ST_TS_HI, ST_TS_LO});
    pending_d  = pending_q;
    ovf_d      = ovf_q;
    lost_d     = lost_q;
    if (grant_fire) begin
      pending_d[grant] = 1'b0;
      ovf_d[grant]     = 1'b0;
    end
    // A strobe on the channel being granted refills pending without counting as a loss.
    for (int i = 0; i < NCH; i++) begin
      if (cap_en && adcstrobe[i]) begin
        if (pending_q[i] && !(grant_fire && grant == PW'(i))) begin
          ovf_d[i]  = 1'b1;
          lost_d[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
    end
    if (flush) begin
      pending_d = '0;
      ovf_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_ADC;
      cnt_q       <= '0;
      adc_rst_q   <= 1'b0;
      running_q   <= 1'b0;
      abort_q     <= 1'b0;
      ptr_q       <= PW'(NCH - 1);
      pending_q   <= '0;
      ovf_q       <= '0;
      lost_q      <= '0;
      snap_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
`ifdef ADC_STREAM_TIMESTAMP_EN
      ts_cnt_q  <= '0;
      ts_snap_q <= '0;
      for (int i = 0; i < NCH; i++) ts_hold_q[i] <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
      for (int i = 0; i < NCH; i++) begin
        if (cap_en && adcstrobe[i]) begin
          hold_q[i] <= adcval[8*i +: 8];
`ifdef ADC_STREAM_TIMESTAMP_EN
          ts_hold_q[i] <= ts_cnt_q;
`endif
        end
      end
`ifdef ADC_STREAM_TIMESTAMP_EN
      ts_cnt_q <= (state_q == ST_RST_ADC || state_q == ST_SETTLE) ? 16'h0000 : ts_cnt_q + 16'h0001;
`endif
      if (!enable) adc_rst_q <= 1'b0;
      if (!enable && (state_q inside {ST_TAG, ST_DATA, ST_TS_HI, ST_TS_LO})) abort_q <= 1'b1;
      if (end_xfer) begin
        out_valid_q <= 1'b0;
        if (abort_q || !enable) begin
          running_q <= 1'b0;
          state_q   <= ST_RST_ADC;
        end else begin
          state_q   <= ST_IDLE;
        end
      end
      case (state_q)
        ST_RST_ADC: begin
          adc_rst_q <= 1'b0;
          running_q <= 1'b0;
          abort_q   <= 1'b0;
          if (!enable) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            cnt_q     <= '0;
            adc_rst_q <= 1'b1;
            state_q   <= ST_SETTLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!enable) begin
            cnt_q   <= '0;
            state_q <= ST_RST_ADC;
          end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_q     <= '0;
            running_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (!enable) begin
            running_q <= 1'b0;
            state_q   <= ST_RST_ADC;
          end else if (any_req) begin
            out_data_q  <= make_tag(TAG_PREFIX, ovf_q[grant], TAG_CH_W'(grant));
            out_valid_q <= 1'b1;
            ptr_q       <= grant;
            snap_q      <= hold_q[grant];
`ifdef ADC_STREAM_TIMESTAMP_EN
            ts_snap_q   <= ts_hold_q[grant];
`endif
            state_q     <= ST_TAG;
          end
        end
        ST_TAG: begin
          if (hs) begin
            out_data_q <= snap_q;
            state_q    <= ST_DATA;
          end
        end
`ifdef ADC_STREAM_TIMESTAMP_EN
        ST_DATA: begin
          if (hs) begin
            out_data_q <= ts_snap_q[15:8];
            state_q    <= ST_TS_HI;
          end
        end
        ST_TS_HI: begin
          if (hs) begin
            out_data_q <= ts_snap_q[7:0];
            state_q    <= ST_TS_LO;
          end
        end
        ST_TS_LO: ;
`else
        ST_DATA: ;
`endif
        default: state_q <= ST_RST_ADC;
      endcase
    end
  end

  assign adc_rst_      = adc_rst_q;
  assign running       = running_q;
  assign lost          = lost_q;
  assign usb.out_data  = out_data_q;
  assign usb.out_valid = out_valid_q;

endmodule
`default_nettype wire
